// File: rtl/pipe_result_buffer.sv
// Credit-issuing result buffer at the tail of a fixed-latency, valid-only pipeline; result-to-output latency is 1 cycle.
// The pipeline is never backpressured (credits guarantee a free slot); the consumer side uses valid/ready.
module pipe_result_buffer #(
    parameter int width      = 8,
    parameter int fifo_depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_vld,
    output logic             issue_ready,
    input  logic             res_vld,
    input  logic [width-1:0] res_data,
    output logic             out_vld,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             err
);
    localparam int CW = $clog2(fifo_depth + 1);
    localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
    localparam logic [PW-1:0] LAST_C  = PW'(fifo_depth - 1);

    logic [CW-1:0]    reserved_q, reserved_d;
    logic [CW-1:0]    in_flight_q, in_flight_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [width-1:0] mem_q [fifo_depth];
    logic             launch, pop, res_bad, res_ok;

    always_comb begin
        issue_ready = !rst && (reserved_q < DEPTH_C);
        out_vld     = !rst && (count_q != '0);
        out_data    = mem_q[rd_ptr_q];
        err         = !rst && err_q;

        launch  = issue_vld && issue_ready;
        pop     = out_vld && out_ready;
        // An unexpected or overflowing return is dropped so occupancy stays consistent.
        res_bad = res_vld && ((in_flight_q == '0) || (count_q == DEPTH_C));
        res_ok  = res_vld && !res_bad;

        reserved_d  = reserved_q + CW'(launch) - CW'(pop);
        in_flight_d = in_flight_q + CW'(launch) - CW'(res_ok);
        count_d     = count_q + CW'(res_ok) - CW'(pop);

        wr_ptr_d = wr_ptr_q;
        if (res_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
        end
        err_d = err_q || res_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reserved_q  <= '0;
            in_flight_q <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            reserved_q  <= reserved_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && res_ok) begin
            mem_q[wr_ptr_q] <= res_data;
        end
    end
endmodule

// File: doc/pipe_result_buffer.md
# pipe_result_buffer

Receiving end of a fixed-latency valid-only pipeline. It issues credits to the launch point of the pipeline, accepts every result the pipeline delivers with no backpressure, and buffers results in a FIFO. Results are presented to a downstream consumer over a valid/ready handshake. Credit accounting guarantees that every result launched into the pipeline has a free FIFO slot when it emerges, so the pipeline itself never needs a stall.

## Interface
- `width`, default 8: data width of results.
- `fifo_depth`, default 4: FIFO entries, equal to the maximum number of launched-but-not-consumed results. Any value ≥ 1; a power of two is not required.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `issue_vld`  input  1  upstream wants to launch a transfer into the pipeline this cycle.
- `issue_ready`  output  1  credit available; a launch is accepted when `issue_vld && issue_ready`.
- `res_vld`  input  1  a result emerges from the pipeline this cycle; it is always accepted.
- `res_data`  input  width  result data, sampled when `res_vld`.
- `out_vld`  output  1  FIFO non-empty; `out_data` is valid.
- `out_ready`  input  1  consumer accepts `out_data`; a pop occurs when `out_vld && out_ready`.
- `out_data`  output  width  head of FIFO (show-ahead).
- `err`  output  1  sticky protocol error flag.

## Operation
- Counters are `$clog2(fifo_depth+1)` bits wide and never wrap; each must saturate or be provably in range.
  - `reserved`: FIFO occupancy plus in-flight results.
  - `in_flight`: results launched but not yet returned.
  - `count`: FIFO occupancy.
- Launch, `issue_vld && issue_ready`:
  - `reserved` increments by 1.
  - `in_flight` increments by 1.
- Return, `res_vld`:
  - `res_data` is written at `wr_ptr`.
  - `wr_ptr` advances.
  - `count` increments by 1.
  - `in_flight` decrements by 1.
  - `reserved` is unchanged.
- Pop, `out_vld && out_ready`:
  - `rd_ptr` advances.
  - `count` decrements by 1.
  - `reserved` decrements by 1.
- Simultaneous events are applied as independent increments and decrements in the same cycle:
  - Launch and pop together leave `reserved` unchanged.
  - Return and pop together leave `count` unchanged.
  - Return and launch together leave `in_flight` unchanged.
- Pointer wrap: a pointer at `fifo_depth-1` goes to 0. Ordering is strict FIFO.
- `issue_ready = !rst && (reserved < fifo_depth)`. It is combinational from registered state only and never depends on `issue_vld`.
- `out_vld = (count != 0)`. `out_data = mem[rd_ptr]`. Both are combinational from registers, with no path from `out_ready`.
- Error conditions:
  - `res_vld` while `in_flight == 0`: set `err`, do not write the FIFO, leave all counters unchanged.
  - `res_vld` while `count == fifo_depth`: set `err`, with the same no-write and no-change rules. This case is unreachable when the credit protocol is obeyed.
  - `err` clears only on reset.
- Reset, applied at any time including mid-operation:
  - All pointers and counters go to 0, and `err` goes to 0.
  - In-flight and buffered results are discarded.
  - FIFO memory contents need not be reset.
  - The upstream pipeline's valid chain resets in the same cycle, so no stale results return.
- `res_vld`, `issue_vld` and `out_ready` are ignored while `rst` is high.

## Timing
- Reset values while `rst` is high and the cycle after:
  - `out_vld` = 0.
  - `err` = 0.
  - `issue_ready` = 0 during reset and 1 in the first cycle after reset.
- Result to output latency is 1 cycle: `res_vld` in cycle t gives `out_vld` = 1 in cycle t+1 with that data, when the FIFO was empty.
- A pop in cycle t frees a credit from cycle t+1: `issue_ready` rises in t+1.
- Full throughput is 1 launch, 1 return and 1 pop per cycle in steady state.
- Pipeline latency L is arbitrary but fixed. The block does not need to know L.
- `fifo_depth` ≥ L+1 is required for gap-free launch with a consumer that is always ready.

## Test plan
- **Single transfer** (`fifo_depth`=4, L=3, `out_ready`=1): launch in cycle 0; `res_vld` with `res_data`=0x5A in cycle 3. Required: `out_vld`=1 and `out_data`=0x5A in cycle 4, popped in cycle 4, `out_vld`=0 in cycle 5. `issue_ready` stays 1 throughout.
- **Credit exhaustion** (`out_ready`=0, `issue_vld`=1 continuously): launches are accepted in cycles 0–3; `issue_ready`=0 from cycle 4. Results 0x10–0x13 return in cycles 3–6, after which `count`=4. Raise `out_ready` for one cycle in cycle 8: 0x10 pops and `issue_ready`=1 in cycle 9.
- **Simultaneous launch and pop** at `reserved`=3: `reserved` stays 3 and `issue_ready` stays 1. A simultaneous return and pop at `count`=2 leaves `count`=2.
- **Wrap-around**: launch values 0..9 with `out_ready` toggling 1,0,1,0. Required: output order 0..9 with none lost or duplicated, and `err` stays 0.
- **Error**: `res_vld` with `in_flight`=0 and data 0xEE. Required: `err`=1 from the next cycle and sticky, 0xEE never appears on `out_data`, counters unchanged.
- **Reset mid-operation**: 2 results in flight and 1 buffered, then `rst` for 1 cycle. Required: `out_vld`=0 and `issue_ready`=1 after reset. A new launch followed by a return of 0x33 produces `out_data`=0x33 only.
